// File: rtl/mfp_avalon_ram_responder_pkg.sv
// Shared types and bus widths for the Avalon-MM block-RAM responder.
package mfp_avalon_ram_responder_pkg;

  localparam int AVM_BURST_W = 3;
  localparam int AVM_DATA_W  = 32;
  localparam int AVM_BE_W    = 4;
  localparam int WCNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } state_t;

endpackage

// File: rtl/mfp_avalon_ram_be.sv
// Simple dual-port RAM: byte-enable write port, registered read port.
module mfp_avalon_ram_be
  import mfp_avalon_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
)(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [AVM_BE_W-1:0]   be,
  input  logic [AVM_DATA_W-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [AVM_DATA_W-1:0] rdata
);

  logic [AVM_DATA_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < AVM_BE_W; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mfp_avalon_ram_responder.sv
// Avalon-MM burst responder backed by block RAM, with programmable
// first-beat wait states and a sticky protocol-error flag.
module mfp_avalon_ram_responder
  import mfp_avalon_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_CYCLES = 0,
  parameter int MAX_BURST   = 4
)(
  input  logic                   avm_clk,
  input  logic                   avm_rst_n,
  input  logic [31:0]            avm_address,
  input  logic                   avm_read,
  input  logic                   avm_write,
  input  logic [AVM_BE_W-1:0]    avm_byteenable,
  input  logic [AVM_BURST_W-1:0] avm_burstcount,
  input  logic                   avm_beginbursttransfer,
  input  logic                   avm_begintransfer,
  input  logic [AVM_DATA_W-1:0]  avm_writedata,
  output logic                   avm_waitrequest,
  output logic                   avm_readdatavalid,
  output logic [AVM_DATA_W-1:0]  avm_readdata,
  output logic                   err_sticky
);

  localparam logic [WCNT_W-1:0]      WAIT_LIM  = WCNT_W'(WAIT_CYCLES);
  localparam logic [AVM_BURST_W-1:0] BURST_LIM = AVM_BURST_W'(MAX_BURST);

  function automatic logic [AVM_BURST_W-1:0] sat_burst(input logic [AVM_BURST_W-1:0] bc);
    if (bc == '0) return AVM_BURST_W'(1);
    if (bc > BURST_LIM) return BURST_LIM;
    return bc;
  endfunction

  function automatic logic burst_illegal(input logic [AVM_BURST_W-1:0] bc);
    return (bc == '0) || (bc > BURST_LIM);
  endfunction

  state_t                  state, state_nxt;
  logic [WCNT_W-1:0]       wcnt;
  logic [ADDR_WIDTH-1:0]   cmd_idx, addr_p0, ram_waddr;
  logic [AVM_BURST_W-1:0]  bc_sat, beats_left, out_left;
  logic                    cmd, wait_req, accept, ram_we, ram_re, proto_err;
  logic                    rd_vld_p0, rd_vld_p1, err_q;
  logic [AVM_DATA_W-1:0]   ram_q, rd_data_p1;
  logic                    unused_ok;

  assign cmd     = avm_read | avm_write;
  assign cmd_idx = avm_address[ADDR_WIDTH+1:2];
  assign bc_sat  = sat_burst(avm_burstcount);
  assign unused_ok = ^{avm_address[31:ADDR_WIDTH+2], avm_address[1:0],
                       avm_beginbursttransfer, avm_begintransfer};

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (avm_write) begin
            if (bc_sat > AVM_BURST_W'(1)) state_nxt = ST_WR_BURST;
          end else begin
            state_nxt = ST_RD_BURST;
          end
        end
      end
      ST_WR_BURST: if (avm_write && beats_left == AVM_BURST_W'(1)) state_nxt = ST_IDLE;
      // Leave as the final beat enters the output register, so waitrequest
      // drops in the same cycle that beat is presented.
      ST_RD_BURST: if (rd_vld_p0 && out_left == AVM_BURST_W'(1)) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_req  = 1'b0;
    accept    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cmd_idx;
    ram_re    = 1'b0;
    case (state)
      ST_IDLE: begin
        wait_req = cmd && (wcnt != WAIT_LIM);
        accept   = cmd && !wait_req;
        ram_we   = accept && avm_write;
      end
      ST_WR_BURST: begin
        ram_we    = avm_write;
        ram_waddr = addr_p0;
      end
      ST_RD_BURST: begin
        wait_req = 1'b1;
        ram_re   = (beats_left != '0);
      end
      default: ;
    endcase
  end

  assign proto_err = ((state == ST_IDLE) && accept &&
                      ((avm_read && avm_write) || burst_illegal(avm_burstcount))) ||
                     ((state == ST_WR_BURST) && avm_read);

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      wcnt       <= '0;
      addr_p0    <= '0;
      beats_left <= '0;
      out_left   <= '0;
      rd_vld_p0  <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
      err_q      <= 1'b0;
    end else begin
      wcnt <= ((state == ST_IDLE) && wait_req) ? wcnt + 1'b1 : '0;
      if (proto_err) err_q <= 1'b1;
      // p0: RAM output register; p1: bus output register
      rd_vld_p0 <= ram_re;
      rd_vld_p1 <= rd_vld_p0;
      if (rd_vld_p0) rd_data_p1 <= ram_q;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (avm_write) begin
              addr_p0    <= cmd_idx + 1'b1;
              beats_left <= bc_sat - 1'b1;
            end else begin
              addr_p0    <= cmd_idx;
              beats_left <= bc_sat;
              out_left   <= bc_sat;
            end
          end
        end
        ST_WR_BURST: begin
          if (avm_write) begin
            addr_p0    <= addr_p0 + 1'b1;
            beats_left <= beats_left - 1'b1;
          end
        end
        ST_RD_BURST: begin
          if (ram_re) begin
            addr_p0    <= addr_p0 + 1'b1;
            beats_left <= beats_left - 1'b1;
          end
          if (rd_vld_p0) out_left <= out_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

  mfp_avalon_ram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (avm_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .be    (avm_byteenable),
    .wdata (avm_writedata),
    .re    (ram_re),
    .raddr (addr_p0),
    .rdata (ram_q)
  );

  assign avm_waitrequest   = !avm_rst_n || wait_req;
  assign avm_readdatavalid = rd_vld_p1;
  assign avm_readdata      = rd_data_p1;
  assign err_sticky        = err_q;

endmodule

// File: tb/tb_mfp_avalon_ram_responder.sv
// Scoreboard bench for mfp_avalon_ram_responder with a word-array reference model.
module tb_mfp_avalon_ram_responder;
  import mfp_avalon_ram_responder_pkg::*;

  localparam int AW    = 8;
  localparam int WAITS = 3;
  localparam int MAXB  = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [2:0]  avm_burstcount;
  logic        avm_beginbursttransfer, avm_begintransfer;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        err_sticky;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  bit          model_err;
  logic [31:0] last_rd = '0;
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] beat_d [4];
  logic [3:0]  beat_be [4];

  mfp_avalon_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITS), .MAX_BURST(MAXB)) dut (
    .avm_clk                (clk),
    .avm_rst_n              (rst_n),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_byteenable         (avm_byteenable),
    .avm_burstcount         (avm_burstcount),
    .avm_beginbursttransfer (avm_beginbursttransfer),
    .avm_begintransfer      (avm_begintransfer),
    .avm_writedata          (avm_writedata),
    .avm_waitrequest        (avm_waitrequest),
    .avm_readdatavalid      (avm_readdatavalid),
    .avm_readdata           (avm_readdata),
    .err_sticky             (err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int eff_bc(input logic [2:0] bc);
    if (bc == 0) return 1;
    if (bc > MAXB) return MAXB;
    return int'(bc);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return (old & ~m) | (d & m);
  endfunction

  // Scoreboard monitor: every presented beat must match the head of the queue
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      if (avm_readdatavalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdv: readdatavalid=1 data 0x%08h with no beat outstanding", avm_readdata);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", avm_readdata, e.data);
          check("rd_cycle", cyc, e.due);
          last_rd = e.data;
        end
      end else begin
        check("rd_hold", avm_readdata, last_rd);
      end
    end
  end

  task automatic stop_now(input string msg);
    $display("FAIL %s", msg);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "aborted");
  endtask

  task automatic wait_idle();
    int t = 0;
    if (exp_q.size() == 0) return;
    while (exp_q.size() != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) stop_now($sformatf("drain: %0d beats still outstanding, expected 0", exp_q.size()));
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input string name);
    int waits = 0;
    @(negedge clk);
    while (avm_waitrequest && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (avm_waitrequest) stop_now($sformatf("%s_accept: waitrequest stuck at 1, expected release", name));
    check({name, "_waits"}, waits, WAITS);
    @(posedge clk); #1;
    avm_begintransfer = 1'b0;
    avm_beginbursttransfer = 1'b0;
  endtask

  task automatic do_write(input int idx, input logic [2:0] bc, input bit both, input int gap_mode);
    int n = eff_bc(bc);
    wait_idle();
    avm_address = 32'(idx) << 2 | 32'($urandom_range(0, 3));
    avm_write = 1'b1;
    avm_read = both;
    avm_burstcount = bc;
    avm_writedata = beat_d[0];
    avm_byteenable = beat_be[0];
    avm_begintransfer = 1'b1;
    avm_beginbursttransfer = 1'b1;
    wait_accept("wr");
    model_mem[idx % DEPTH] = merge(model_mem[idx % DEPTH], beat_d[0], beat_be[0]);
    if (both || bc == 0 || bc > MAXB) model_err = 1'b1;
    avm_read = 1'b0;
    for (int k = 1; k < n; k++) begin
      if ((gap_mode == 2 && k == 1) || (gap_mode == 1 && $urandom_range(0, 2) == 0)) begin
        avm_write = 1'b0;
        avm_read = (gap_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (avm_read) model_err = 1'b1;
        avm_writedata = $urandom;
        @(negedge clk);
        check("gap_waitrequest", avm_waitrequest, 0);
        @(posedge clk); #1;
        avm_read = 1'b0;
      end
      avm_write = 1'b1;
      avm_writedata = beat_d[k];
      avm_byteenable = beat_be[k];
      avm_address = $urandom;
      avm_burstcount = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("wr_beat_waitrequest", avm_waitrequest, 0);
      @(posedge clk); #1;
      model_mem[(idx + k) % DEPTH] = merge(model_mem[(idx + k) % DEPTH], beat_d[k], beat_be[k]);
    end
    avm_write = 1'b0;
    check("err_sticky_wr", err_sticky, model_err);
  endtask

  task automatic do_read(input int idx, input logic [2:0] bc);
    int n = eff_bc(bc);
    exp_t e;
    wait_idle();
    avm_address = 32'(idx) << 2 | 32'($urandom_range(0, 3));
    avm_read = 1'b1;
    avm_write = 1'b0;
    avm_burstcount = bc;
    avm_byteenable = 4'($urandom);
    avm_begintransfer = 1'b1;
    avm_beginbursttransfer = 1'b1;
    wait_accept("rd");
    for (int k = 0; k < n; k++) begin
      e.data = model_mem[(idx + k) % DEPTH];
      e.due = cyc + 2 + k;
      exp_q.push_back(e);
    end
    if (bc == 0 || bc > MAXB) model_err = 1'b1;
    avm_read = 1'b0;
    check("err_sticky_rd", err_sticky, model_err);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    avm_read = 1'b0;
    avm_write = 1'b0;
    #1;
    check("rst_waitrequest", avm_waitrequest, 1);
    check("rst_readdatavalid", avm_readdatavalid, 0);
    check("rst_readdata", avm_readdata, 0);
    check("rst_err_sticky", err_sticky, 0);
    exp_q.delete();
    model_err = 1'b0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_waitrequest", avm_waitrequest, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    stop_now("watchdog: simulation time limit reached");
  end

  initial begin
    int t;
    rst_n = 1'b1;
    avm_address = '0; avm_read = 1'b0; avm_write = 1'b0; avm_byteenable = '0;
    avm_burstcount = 3'd1; avm_beginbursttransfer = 1'b0; avm_begintransfer = 1'b0;
    avm_writedata = '0;
    #2 rst_n = 1'b0;
    apply_reset();

    // Prefill every word so the model and the RAM agree everywhere
    for (int i = 0; i < DEPTH / 4; i++) begin
      for (int k = 0; k < 4; k++) begin beat_d[k] = $urandom; beat_be[k] = 4'hF; end
      do_write(i * 4, 3'd4, 1'b0, 0);
    end

    // Single write then read at byte address 0x10
    beat_d[0] = 32'hDEADBEEF; beat_be[0] = 4'hF;
    do_write(32'h10 >> 2, 3'd1, 1'b0, 0);
    do_read(32'h10 >> 2, 3'd1);

    // Byte-lane merge
    beat_d[0] = 32'h11223344; beat_be[0] = 4'hF;
    do_write(8, 3'd1, 1'b0, 0);
    beat_d[0] = 32'hAABBCCDD; beat_be[0] = 4'b0101;
    do_write(8, 3'd1, 1'b0, 0);
    do_read(8, 3'd1);

    // Wrapping burst at the top word with a forced gap
    for (int k = 0; k < 4; k++) begin beat_d[k] = 32'hC0DE0000 + k; beat_be[k] = 4'hF; end
    do_write(DEPTH - 1, 3'd4, 1'b0, 2);
    do_read(DEPTH - 1, 3'd4);

    // Reset in the middle of a read burst, then a clean read
    do_read(20, 3'd4);
    t = 0;
    while (exp_q.size() > 3 && t < 10) begin @(negedge clk); t++; end
    apply_reset();
    do_read(20, 3'd2);

    // Violations: read&write together, burstcount 0, oversize burst
    beat_d[0] = 32'h0BAD0001; beat_be[0] = 4'hF;
    do_write(40, 3'd1, 1'b1, 0);
    do_read(40, 3'd1);
    apply_reset();
    beat_d[0] = 32'h0BAD0002; beat_d[1] = 32'h0BAD0003; beat_be[1] = 4'hF;
    do_write(50, 3'd0, 1'b0, 0);
    do_read(50, 3'd2);
    check("err_persists", err_sticky, 1);
    apply_reset();
    do_read(60, 3'd7);
    apply_reset();

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      int idx = $urandom_range(0, DEPTH - 1);
      int r = $urandom_range(0, 9);
      logic [2:0] bc = (r == 0) ? 3'd0 : (r == 1) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 4; k++) begin beat_d[k] = $urandom; beat_be[k] = 4'($urandom); end
        do_write(idx, bc, ($urandom_range(0, 9) == 0), 1);
      end else begin
        do_read(idx, bc);
      end
      if (i % 20 == 19) apply_reset();
    end
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
